cpu_core_mc: RTL and testbench

- Synthesizable, parametrised multi-cycle successor to the behavioural CPU model.
- Executes the same 10-opcode ISA (NOP, LD, STR, BRA, XOR, ADD, ROT, SHF, HLT, CMP) and the same 5-bit PSR, with data width as a parameter.
- Adds a req/ack memory port with wait states, true rotate-through-carry, and signed shift/rotate counts.
- Sits between the shared instruction/data memory and the test harness; a debug port exposes pc, psr, halted and a retire pulse.

---
 rtl/cpu_core_mc.sv | 136 +++++++++++++
 tb/tb_cpu_core_mc.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle 10-opcode CPU with req/ack memory port, parametrised data width
module cpu_core_mc #(
  parameter int BUSW = 32,
  parameter int MINDW = 12,
  parameter int RINDW = 4,
  parameter logic [MINDW-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             mem_req,
  output logic             mem_we,
  output logic [MINDW-1:0] mem_addr,
  output logic [BUSW-1:0]  mem_wdata,
  input  logic [BUSW-1:0]  mem_rdata,
  input  logic             mem_ack,
  output logic             halted,
  output logic             retire,
  output logic [MINDW-1:0] pc,
  output logic [4:0]       psr
);
  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
  localparam logic [3:0] OP_LD = 4'd1, OP_STR = 4'd2, OP_BRA = 4'd3, OP_XOR = 4'd4,
                         OP_ADD = 4'd5, OP_ROT = 4'd6, OP_SHF = 4'd7, OP_HLT = 4'd8,
                         OP_CMP = 4'd9;
  state_t state, nstate;
  logic [31:0] ir;
  logic [BUSW-1:0] regs [2**RINDW];
  logic [3:0] op, cc;
  logic [RINDW-1:0] si, di;
  logic [BUSW-1:0] imm, sv, dv, res, wdata;
  logic [4:0] cnt, mag;
  logic [BUSW:0] rx, rl, rr;
  logic cl, cr, cres, wr, fl, taken, req, we;
  logic [MINDW-1:0] addr;
  logic [7:0] cond;
  assign op = ir[31:28];
  assign cc = ir[27:24];
  assign si = ir[12+RINDW-1:12];
  assign di = ir[RINDW-1:0];
  assign imm = BUSW'(ir[23:12]);
  assign sv = ir[27] ? imm : regs[si];
  assign dv = regs[di];
  assign cnt = ir[16:12];
  assign mag = cnt[4] ? 5'd0 - cnt : cnt;
  // carry-out of a logical shift is the last bit pushed past the word boundary
  assign cl = |(dv & (BUSW'(1) << (BUSW - int'(mag))));
  assign cr = |(dv & (BUSW'(1) << (mag - 5'd1)));
  assign rx = {psr[0], dv};
  assign rl = (rx << mag) | (rx >> (BUSW + 1 - int'(mag)));
  assign rr = (rx >> mag) | (rx << (BUSW + 1 - int'(mag)));
  assign cond = {~psr[3], ~psr[0], psr[4], psr[3], psr[0], psr[2], psr[1], 1'b1};
  always_comb begin
    nstate = state;
    res = '0;
    cres = 1'b0;
    wr = 1'b0;
    fl = 1'b0;
    taken = 1'b0;
    retire = 1'b0;
    req = 1'b0;
    we = 1'b0;
    addr = '0;
    wdata = '0;
    case (state)
      FETCH: begin
        req = 1'b1;
        addr = pc;
        nstate = mem_ack ? EXEC : FETCH;
      end
      EXEC: begin
        retire = 1'b1;
        nstate = FETCH;
        case (op)
          OP_LD: begin
            res = sv;
            wr = ir[27];
            fl = ir[27];
            retire = ir[27];
            nstate = ir[27] ? FETCH : MEM;
          end
          OP_STR: begin
            retire = 1'b0;
            nstate = MEM;
          end
          OP_BRA: taken = ~cc[3] & cond[cc[2:0]];
          OP_XOR: {wr, fl, res} = {2'b11, dv ^ sv};
          OP_ADD: {wr, fl, cres, res} = {2'b11, {1'b0, dv} + {1'b0, sv}};
          OP_CMP: {wr, fl, res} = {2'b11, ~sv};
          OP_SHF: begin
            {wr, fl} = 2'b11;
            res = cnt == 5'd0 ? dv : cnt[4] ? dv >> mag : dv << mag;
            cres = cnt == 5'd0 ? 1'b0 : cnt[4] ? cr : cl;
          end
          OP_ROT: {wr, fl, cres, res} = {2'b11, cnt == 5'd0 ? rx : cnt[4] ? rr : rl};
          OP_HLT: nstate = HALT;
          default: ;
        endcase
      end
      MEM: begin
        req = 1'b1;
        we = op == OP_STR;
        addr = we ? ir[MINDW-1:0] : ir[12+MINDW-1:12];
        wdata = sv;
        if (mem_ack) begin
          retire = 1'b1;
          nstate = FETCH;
          res = we ? sv : mem_rdata;
          wr = ~we;
          fl = 1'b1;
        end
      end
      default: ;
    endcase
  end
  // reset forces the port quiet at once, even though the state register restarts in FETCH
  assign mem_req = rst_n & req;
  assign mem_we = rst_n & we;
  assign mem_addr = rst_n ? addr : '0;
  assign mem_wdata = rst_n ? wdata : '0;
  assign halted = state == HALT || (state == EXEC && op == OP_HLT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      ir <= '0;
      pc <= RESET_PC;
      psr <= '0;
      for (int i = 0; i < 2**RINDW; i++) regs[i] <= '0;
    end else begin
      state <= nstate;
      if (state == FETCH && mem_ack) ir <= mem_rdata[31:0];
      if (wr) regs[di] <= res;
      if (fl) psr <= {res == '0, res[BUSW-1], ~res[0], ^res, cres};
      if (retire) pc <= taken ? ir[MINDW-1:0] : pc + MINDW'(1);
    end
  end
endmodule

// File: tb/tb_cpu_core_mc.sv
// tb_cpu_core_mc: directed self-checking bench for cpu_core_mc (main core plus a 4-bit-PC core)
module tb_cpu_core_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, rst2_n = 1'b0;
  logic req1, we1, ack1, halted1, retire1;
  logic [11:0] addr1, pc1;
  logic [31:0] wdata1, rdata1;
  logic [4:0] psr1;
  logic req2, we2, halted2, retire2;
  logic [3:0] addr2, pc2;
  logic [31:0] wdata2, rdata2;
  logic [4:0] psr2;
  int compared = 0, mismatched = 0;
  logic [31:0] mem [4096];
  logic [31:0] smem [4096];
  int sep [4096];
  int epoch = 1;
  logic [31:0] mem2 [16];
  int ws = 0;
  logic hold_ack = 1'b0;
  int wc = 0, reqc = 0, ackc = 0, retc = 0, reqc2 = 0, retc2 = 0;

  cpu_core_mc dut (
    .clk(clk), .rst_n(rst_n), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_ack(ack1), .halted(halted1),
    .retire(retire1), .pc(pc1), .psr(psr1)
  );
  cpu_core_mc #(.MINDW(4), .RESET_PC(4'd14)) dut2 (
    .clk(clk), .rst_n(rst2_n), .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
    .mem_wdata(wdata2), .mem_rdata(rdata2), .mem_ack(1'b1), .halted(halted2),
    .retire(retire2), .pc(pc2), .psr(psr2)
  );

  assign ack1 = req1 && !hold_ack && (wc == ws);
  assign rdata1 = (sep[addr1] == epoch) ? smem[addr1] : mem[addr1];
  assign rdata2 = mem2[addr2];
  always @(posedge clk) begin
    wc <= (req1 && !ack1) ? wc + 1 : 0;
    if (req1 && we1 && ack1) begin
      smem[addr1] <= wdata1;
      sep[addr1] <= epoch;
    end
    reqc <= reqc + int'(req1);
    ackc <= ackc + int'(req1 && ack1);
    retc <= retc + int'(retire1);
    reqc2 <= reqc2 + int'(req2);
    retc2 <= retc2 + int'(retire2);
  end

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] b,
                                      input logic [11:0] s, input logic [11:0] d);
    return {op, b, s, d};
  endfunction

  function automatic logic [31:0] rd(input int a);
    return (sep[a] == epoch) ? smem[a] : mem[a];
  endfunction

  task automatic clear_mem;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    epoch++;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!retire1 && lat < 40);
    if (!retire1) begin
      compared++;
      mismatched++;
      $display("FAIL step_timeout: no retire within %0d cycles (pc=%0d)", lat, pc1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    ws = 0;
    hold_ack = 1'b0;
    clear_mem;
    mem[0] = enc(4'd2, 4'd8, 12'd5, 12'd210);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({req1, we1, halted1, retire1, addr1, pc1, psr1, wdata1} !== 66'h0) begin
      mismatched++;
      $display("FAIL reset_values: got req=%b we=%b hlt=%b ret=%b addr=%h pc=%h psr=%b wd=%h want all zero",
               req1, we1, halted1, retire1, addr1, pc1, psr1, wdata1);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1 hold_ack = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if ({req1, we1, addr1, wdata1} !== {1'b1, 1'b1, 12'd210, 32'd5}) begin
      mismatched++;
      $display("FAIL mem_str_port: got req=%b we=%b addr=%0d wd=%h want 1 1 210 00000005",
               req1, we1, addr1, wdata1);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    compared++;
    if ({req1, we1, addr1} !== 14'h0) begin
      mismatched++;
      $display("FAIL reset_mid_mem: got req=%b we=%b addr=%0d want 0 0 0", req1, we1, addr1);
    end
    hold_ack = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    compared++;
    if ({req1, we1, addr1} !== {1'b1, 1'b0, 12'd0}) begin
      mismatched++;
      $display("FAIL refetch_after_reset: got req=%b we=%b addr=%0d want 1 0 0", req1, we1, addr1);
    end
    compared++;
    if (rd(210) !== 32'h0) begin
      mismatched++;
      $display("FAIL abandoned_store: mem[210]=%h want 00000000", rd(210));
    end
  endtask

  task automatic test_imm_ops;
    logic [4:0] ep [6] = '{5'h00, 5'h06, 5'h08, 5'h15, 5'h06, 5'h06};
    int el [6] = '{2, 2, 2, 2, 3, 2};
    int lat;
    ws = 0;
    clear_mem;
    mem[0] = enc(4'd1, 4'd8, 12'hFFF, 12'd1);
    mem[1] = enc(4'd5, 4'd8, 12'd1, 12'd1);
    mem[2] = enc(4'd9, 4'd8, 12'd0, 12'd2);
    mem[3] = enc(4'd5, 4'd8, 12'd1, 12'd2);
    mem[4] = enc(4'd2, 4'd0, 12'd1, 12'd200);
    mem[5] = enc(4'd8, 4'd0, 12'd0, 12'd0);
    do_reset;
    for (int i = 0; i < 6; i++) begin
      step(lat);
      compared++;
      if (psr1 !== ep[i] || pc1 !== 12'(i + 1) || lat !== el[i]) begin
        mismatched++;
        $display("FAIL imm_step%0d: got psr=%b pc=%0d lat=%0d want psr=%b pc=%0d lat=%0d",
                 i, psr1, pc1, lat, ep[i], i + 1, el[i]);
      end
    end
    compared++;
    if (rd(200) !== 32'h0000_1000 || halted1 !== 1'b1) begin
      mismatched++;
      $display("FAIL imm_result: got mem[200]=%h halted=%b want 00001000 1", rd(200), halted1);
    end
  endtask

  task automatic test_shift_rotate;
    logic [4:0] ep [9] = '{5'h08, 5'h07, 5'h15, 5'h02, 5'h15, 5'h0E, 5'h0E, 5'h14, 5'h14};
    int el [9] = '{3, 2, 2, 2, 2, 2, 3, 3, 2};
    int lat;
    ws = 0;
    clear_mem;
    mem[300] = 32'h8000_0001;
    mem[0] = enc(4'd1, 4'd0, 12'd300, 12'd3);
    mem[1] = enc(4'd7, 4'd0, 12'h001, 12'd3);
    mem[2] = enc(4'd7, 4'd0, 12'h01E, 12'd3);
    mem[3] = enc(4'd1, 4'd8, 12'd1, 12'd4);
    mem[4] = enc(4'd6, 4'd0, 12'h01F, 12'd4);
    mem[5] = enc(4'd6, 4'd0, 12'h01F, 12'd4);
    mem[6] = enc(4'd2, 4'd0, 12'd4, 12'd201);
    mem[7] = enc(4'd2, 4'd0, 12'd3, 12'd202);
    mem[8] = enc(4'd8, 4'd0, 12'd0, 12'd0);
    do_reset;
    for (int i = 0; i < 9; i++) begin
      step(lat);
      compared++;
      if (psr1 !== ep[i] || lat !== el[i]) begin
        mismatched++;
        $display("FAIL shrot_step%0d: got psr=%b lat=%0d want psr=%b lat=%0d",
                 i, psr1, lat, ep[i], el[i]);
      end
    end
    compared++;
    if (rd(201) !== 32'h8000_0000 || rd(202) !== 32'h0) begin
      mismatched++;
      $display("FAIL shrot_result: got R4=%h R3=%h want 80000000 00000000", rd(201), rd(202));
    end
  endtask

  task automatic test_wait_states;
    int el [5] = '{5, 9, 9, 9, 5};
    int lat, rq0, ak0, rt0;
    ws = 3;
    clear_mem;
    mem[0] = enc(4'd1, 4'd8, 12'h5A5, 12'd1);
    mem[1] = enc(4'd2, 4'd0, 12'd1, 12'd100);
    mem[2] = enc(4'd1, 4'd0, 12'd100, 12'd5);
    mem[3] = enc(4'd2, 4'd0, 12'd5, 12'd101);
    mem[4] = enc(4'd8, 4'd0, 12'd0, 12'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rq0 = reqc;
    ak0 = ackc;
    rt0 = retc;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      step(lat);
      compared++;
      if (lat !== el[i] || pc1 !== 12'(i + 1)) begin
        mismatched++;
        $display("FAIL ws_step%0d: got lat=%0d pc=%0d want lat=%0d pc=%0d", i, lat, pc1, el[i], i + 1);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    compared++;
    if (reqc - rq0 !== 32 || ackc - ak0 !== 8 || retc - rt0 !== 5) begin
      mismatched++;
      $display("FAIL ws_counts: got req_cycles=%0d acks=%0d retires=%0d want 32 8 5",
               reqc - rq0, ackc - ak0, retc - rt0);
    end
    compared++;
    if (rd(100) !== 32'h5A5 || rd(101) !== 32'h5A5) begin
      mismatched++;
      $display("FAIL ws_data: got mem[100]=%h mem[101]=%h want 000005a5 000005a5", rd(100), rd(101));
    end
    ws = 0;
  endtask

  task automatic test_branch;
    logic [11:0] epc [7] = '{12'd1, 12'd2, 12'd40, 12'd41, 12'd42, 12'd50, 12'd51};
    logic [4:0] ep [7] = '{5'h02, 5'h06, 5'h06, 5'h06, 5'h06, 5'h06, 5'h06};
    int lat;
    ws = 0;
    clear_mem;
    mem[0] = enc(4'd1, 4'd8, 12'd1, 12'd1);
    mem[1] = enc(4'd5, 4'd8, 12'd1, 12'd1);
    mem[2] = enc(4'd3, 4'd6, 12'd0, 12'd40);
    mem[40] = enc(4'd3, 4'd3, 12'd0, 12'd10);
    mem[41] = enc(4'd3, 4'd9, 12'd0, 12'd10);
    mem[42] = enc(4'd3, 4'd0, 12'd0, 12'd50);
    mem[50] = enc(4'd8, 4'd0, 12'd0, 12'd0);
    do_reset;
    for (int i = 0; i < 7; i++) begin
      step(lat);
      compared++;
      if (pc1 !== epc[i] || psr1 !== ep[i]) begin
        mismatched++;
        $display("FAIL branch_step%0d: got pc=%0d psr=%b want pc=%0d psr=%b", i, pc1, psr1, epc[i], ep[i]);
      end
    end
  endtask

  task automatic test_wrap_halt;
    int rq0, rt0;
    for (int i = 0; i < 16; i++) mem2[i] = 32'h0;
    mem2[0] = enc(4'd8, 4'd0, 12'd0, 12'd0);
    rst2_n = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (pc2 !== 4'd14 || req2 !== 1'b0) begin
      mismatched++;
      $display("FAIL wrap_reset: got pc=%0d req=%b want 14 0", pc2, req2);
    end
    rst2_n = 1'b1;
    #1;
    compared++;
    if (addr2 !== 4'd14 || req2 !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_first_fetch: got addr=%0d req=%b want 14 1", addr2, req2);
    end
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (pc2 !== 4'd15) begin
      mismatched++;
      $display("FAIL wrap_pc15: got pc=%0d want 15", pc2);
    end
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (pc2 !== 4'd0) begin
      mismatched++;
      $display("FAIL wrap_pc0: got pc=%0d want 0", pc2);
    end
    rt0 = retc2;
    repeat (2) @(posedge clk);
    #1;
    rq0 = reqc2;
    compared++;
    if (halted2 !== 1'b1 || pc2 !== 4'd1 || retc2 - rt0 !== 1) begin
      mismatched++;
      $display("FAIL halt_entry: got halted=%b pc=%0d retires=%0d want 1 1 1", halted2, pc2, retc2 - rt0);
    end
    repeat (20) @(posedge clk);
    #1;
    compared++;
    if (reqc2 - rq0 !== 0 || retc2 - rt0 !== 1 || halted2 !== 1'b1) begin
      mismatched++;
      $display("FAIL halt_absorb: got req_cycles=%0d retires=%0d halted=%b want 0 1 1",
               reqc2 - rq0, retc2 - rt0, halted2);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_imm_ops;
    test_shift_rotate;
    test_wait_states;
    test_branch;
    test_wrap_halt;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
